// File: rtl/mux_tree_pipelined_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_pkg : mode encodings and select-width helper for mux blocks    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mux_pkg;

  localparam logic MUX_MODE_DIRECT = 1'b0;
  localparam logic MUX_MODE_RR     = 1'b1;

  // Select width for an n-way mux; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_tree_pipelined_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_tree_pipelined_if : valid/ready input and output beat bundle   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mux_tree_pipelined_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 8
);
  localparam int SELW = mux_pkg::sel_width(N_CH);

  logic                  in_valid;
  logic                  in_ready;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [SELW-1:0]       sel;
  logic                  mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SELW-1:0]       out_ch;

  modport master (
    output in_valid, in_data, sel, mode, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, sel, mode, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface
`default_nettype wire

// File: rtl/mux_tree_pipelined_mux_2by1_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_2by1_reg : 2:1 mux with enabled output register                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mux_2by1_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= sel ? d1 : d0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_tree_pipelined.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_tree_pipelined : N_CH:1 registered binary mux tree, valid/ready|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mux_tree_pipelined
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_CH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_tree_pipelined_if.slave  bus
);

  localparam int LEVELS = sel_width(N_CH);
  localparam int SELW   = LEVELS;

  // Heap-ordered tree: node i has children 2i and 2i+1, leaves at N_CH..2*N_CH-1, root at 1.
  logic [WIDTH-1:0] w_node [1:2*N_CH-1];
  logic [SELW-1:0]  r_sel  [LEVELS];
  logic             r_vld  [LEVELS];
  logic [SELW-1:0]  r_rr_ptr;
  logic [SELW-1:0]  w_eff_sel;
  logic             w_stall;
  logic             w_en;
  logic             w_accept;

  assign w_stall      = bus.out_valid && !bus.out_ready;
  assign w_en         = !w_stall;
  assign w_accept     = bus.in_valid && !w_stall;
  assign bus.in_ready = !w_stall;
  assign w_eff_sel    = (bus.mode == MUX_MODE_RR) ? r_rr_ptr : bus.sel;

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_leaf
      assign w_node[N_CH+c] = bus.in_data[c*WIDTH +: WIDTH];
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int BASE = N_CH >> (k + 1);
      logic w_bit;

      // Level 0 steers on the live select; deeper levels use the select carried with the beat.
      if (k == 0) begin : g_first
        assign w_bit = w_eff_sel[0];
      end else begin : g_rest
        assign w_bit = r_sel[k-1][k];
      end

      for (genvar j = 0; j < BASE; j++) begin : g_node
        mux_2by1_reg #(.WIDTH(WIDTH)) u_mux (
          .clk   (clk),
          .rst_n (rst_n),
          .en    (w_en),
          .sel   (w_bit),
          .d0    (w_node[2*(BASE+j)]),
          .d1    (w_node[2*(BASE+j)+1]),
          .q     (w_node[BASE+j])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LEVELS; k++) begin
        r_vld[k] <= 1'b0;
        r_sel[k] <= '0;
      end
    end else if (w_en) begin
      r_vld[0] <= w_accept;
      r_sel[0] <= w_eff_sel;
      for (int k = 1; k < LEVELS; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_sel[k] <= r_sel[k-1];
      end
    end
  end

  // N_CH is a power of two, so the natural counter overflow is the wrap to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_accept && (bus.mode == MUX_MODE_RR)) begin
      r_rr_ptr <= r_rr_ptr + 1'b1;
    end
  end

  assign bus.out_valid = r_vld[LEVELS-1];
  assign bus.out_ch    = r_sel[LEVELS-1];
  assign bus.out_data  = w_node[1];

endmodule
`default_nettype wire

// File: tb/tb_mux_tree_pipelined.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mux_tree_pipelined : directed scoreboard bench, N_CH=8 WIDTH=8  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mux_tree_pipelined;

  localparam int WIDTH  = 8;
  localparam int N_CH   = 8;
  localparam int LEVELS = 3;
  localparam int SELW   = 3;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  ch;
    int               cyc;
    bit               chk_lat;
  } exp_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  int              cyc      = 0;
  int              n_vec    = 0;
  int              n_miscmp = 0;
  exp_t            sb_q[$];
  logic [SELW-1:0] m_rr   = '0;
  bit              lat_en = 1'b1;
  bit              prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic [SELW-1:0]  prev_ch;

  mux_tree_pipelined_if #(.WIDTH(WIDTH), .N_CH(N_CH)) bus ();

  mux_tree_pipelined #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one beat from just after a rising edge and hold it until accepted.
  task automatic send(input logic md, input logic [SELW-1:0] s, output int waits);
    exp_t e;
    logic [SELW-1:0] eff;
    bit done;
    bus.in_valid = 1'b1;
    bus.mode     = md;
    bus.sel      = s;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        eff       = md ? m_rr : s;
        e.data    = 8'h10 + 8'(eff);
        e.ch      = eff;
        e.cyc     = cyc;
        e.chk_lat = lat_en;
        sb_q.push_back(e);
        if (md) m_rr = (m_rr == SELW'(N_CH - 1)) ? '0 : m_rr + 1'b1;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          check("send_timeout", waits, 50);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(tag, sb_q.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, prev_data);
        check("hold_ch", bus.out_ch, prev_ch);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        check("unexpected_beat", (sb_q.size() == 0), 0);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_ch", bus.out_ch, e.ch);
          if (e.chk_lat) check("latency", cyc - e.cyc, LEVELS);
        end
      end
      prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      prev_data  = bus.out_data;
      prev_ch    = bus.out_ch;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w;
    int n;
    bus.in_valid  = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < N_CH; c++) bus.in_data[c*WIDTH +: WIDTH] = 8'h10 + 8'(c);

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Direct select, single beat, explicit latency count
    send(1'b0, 3'd5, w);
    idle();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.out_valid !== 1'b1 && n < 10);
    check("direct_latency", n, LEVELS);
    drain("direct_drain");

    // Back-to-back streaming of every channel
    for (int i = 0; i < N_CH; i++) begin
      send(1'b0, SELW'(i), w);
      check("stream_in_ready", w, 0);
    end
    idle();
    drain("stream_drain");

    // Round-robin: ten beats wrap the pointer to 2
    for (int i = 0; i < 10; i++) send(1'b1, 3'd0, w);
    idle();
    drain("rr_drain");

    // Backpressure: stall the output for five cycles at the first valid
    lat_en = 1'b0;
    fork
      begin
        send(1'b0, 3'd1, w);
        send(1'b0, 3'd3, w);
        send(1'b0, 3'd5, w);
        send(1'b0, 3'd7, w);
        idle();
      end
      begin
        int t = 0;
        while (bus.out_valid !== 1'b1 && t < 20) begin
          @(posedge clk);
          #1;
          t++;
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", bus.in_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    lat_en = 1'b1;

    // Advance the pointer from 2 to 7, then interleave modes
    for (int i = 0; i < 5; i++) send(1'b1, 3'd0, w);
    send(1'b0, 3'd6, w);
    send(1'b1, 3'd0, w);
    send(1'b1, 3'd0, w);
    send(1'b0, 3'd3, w);
    idle();
    drain("mode_drain");

    // Reset pulse with beats in flight and the oldest one on the output
    send(1'b1, 3'd0, w);
    send(1'b1, 3'd0, w);
    send(1'b1, 3'd0, w);
    idle();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_out_ch", bus.out_ch, 0);
    sb_q.delete();
    m_rr = '0;
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    drain("midrst_no_stale");
    send(1'b1, 3'd0, w);
    idle();
    drain("midrst_rr_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire
